// File: rtl/atm_pkg.sv
// Shared encodings for the ATM session controller: FSM states, display
// screen codes driven onto the 4:1 mux select, and operation codes.
package atm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PIN    = 3'd1,
    ST_MENU   = 3'd2,
    ST_RESULT = 3'd3,
    ST_LOCKED = 3'd4
  } state_t;

  localparam logic [1:0] SCR_IDLE   = 2'd0;
  localparam logic [1:0] SCR_PIN    = 2'd1;
  localparam logic [1:0] SCR_MENU   = 2'd2;
  localparam logic [1:0] SCR_RESULT = 2'd3;
  localparam logic [1:0] SCR_LOCKED = 2'd3;

  localparam logic [1:0] OP_BALANCE  = 2'd0;
  localparam logic [1:0] OP_WITHDRAW = 2'd1;

  // Screen shown for a given state; RESULT and LOCKED share mux input 3.
  function automatic logic [1:0] screen_of(input state_t s);
    case (s)
      ST_IDLE:   screen_of = SCR_IDLE;
      ST_PIN:    screen_of = SCR_PIN;
      ST_MENU:   screen_of = SCR_MENU;
      ST_RESULT: screen_of = SCR_RESULT;
      ST_LOCKED: screen_of = SCR_LOCKED;
      default:   screen_of = SCR_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/atm_timer.sv
// Cycle timer: down-counter reloaded by clr, decremented while en is high.
// tc is asserted during the TC_CYC-th enabled cycle after a clear, so the
// consumer acts on the edge that ends exactly TC_CYC cycles.
module atm_timer #(
  parameter int unsigned TC_CYC = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned W = (TC_CYC > 1) ? $clog2(TC_CYC) : 1;
  localparam logic [W-1:0] LOAD = W'(TC_CYC - 1);

  logic [W-1:0] cnt;

  // Reload on clear, otherwise count down to zero and hold there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= LOAD;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = en && (cnt == '0);

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM session controller: card detect, PIN check with lockout, balance and
// withdraw operations, idle timeout. All outputs are registered.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no session; waiting for a card insertion edge
// ST_PIN    | waiting for PIN entry; wrong entries counted toward lockout
// ST_MENU   | authenticated; waiting for an operation
// ST_RESULT | result screen held for RESULT_CYC cycles, strobes ignored
// ST_LOCKED | too many wrong PINs; card_lock high until the card is removed
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter logic [3:0]  PIN_CODE    = 4'd7,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned RESULT_CYC  = 8,
  parameter logic [7:0]  BAL_INIT    = 8'd100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       card_in,
  input  logic       pin_valid,
  input  logic [3:0] pin,
  input  logic       op_valid,
  input  logic [1:0] op,
  input  logic [3:0] amt,
  output logic [1:0] mux_sel,
  output logic       dispense,
  output logic [3:0] dispense_amt,
  output logic [7:0] balance,
  output logic       err,
  output logic       card_lock
);

  localparam int unsigned TW = $clog2(MAX_TRIES + 1);

  state_t        state, state_nxt;
  logic          card_q;
  logic [TW-1:0] tries, tries_nxt, tries_inc;
  logic [7:0]    bal_nxt;
  logic [3:0]    disp_amt_nxt;
  logic          disp_nxt, err_nxt;
  logic          to_en, to_clr, to_tc;
  logic          res_en, res_clr, res_tc;

  assign tries_inc = tries + 1'b1;

  // Idle timeout runs only in PIN/MENU; any strobe or leaving those states
  // restarts it, which also gives a fresh count on entry.
  assign to_en  = (state == ST_PIN) || (state == ST_MENU);
  assign to_clr = !to_en || pin_valid || op_valid;
  assign res_en  = (state == ST_RESULT);
  assign res_clr = !res_en;

  atm_timer #(.TC_CYC(TIMEOUT_CYC)) u_timeout (
    .clk(clk), .rst_n(rst_n), .clr(to_clr), .en(to_en), .tc(to_tc)
  );

  atm_timer #(.TC_CYC(RESULT_CYC)) u_result (
    .clk(clk), .rst_n(rst_n), .clr(res_clr), .en(res_en), .tc(res_tc)
  );

  // Next state and next registered outputs; card removal beats timeout beats strobe.
  always_comb begin
    state_nxt    = state;
    tries_nxt    = tries;
    bal_nxt      = balance;
    disp_nxt     = 1'b0;
    disp_amt_nxt = dispense_amt;
    err_nxt      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (card_in && !card_q) begin
          state_nxt = ST_PIN;
          tries_nxt = '0;
        end
      end
      ST_PIN: begin
        if (!card_in || to_tc) begin
          state_nxt = ST_IDLE;
        end else if (pin_valid) begin
          if (pin == PIN_CODE) begin
            state_nxt = ST_MENU;
          end else begin
            err_nxt   = 1'b1;
            tries_nxt = tries_inc;
            if (tries_inc == TW'(MAX_TRIES)) state_nxt = ST_LOCKED;
          end
        end
      end
      ST_MENU: begin
        if (!card_in || to_tc) begin
          state_nxt = ST_IDLE;
        end else if (op_valid) begin
          case (op)
            OP_BALANCE: state_nxt = ST_RESULT;
            OP_WITHDRAW: begin
              state_nxt = ST_RESULT;
              if ({4'b0000, amt} <= balance) begin
                bal_nxt      = balance - {4'b0000, amt};
                disp_nxt     = 1'b1;
                disp_amt_nxt = amt;
              end else begin
                err_nxt = 1'b1;
              end
            end
            default: state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_RESULT: begin
        if (!card_in)    state_nxt = ST_IDLE;
        else if (res_tc) state_nxt = ST_MENU;
      end
      ST_LOCKED: begin
        if (!card_in) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register plus registered outputs, all updated on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      mux_sel      <= SCR_IDLE;
      card_lock    <= 1'b0;
      card_q       <= 1'b0;
      tries        <= '0;
      balance      <= BAL_INIT;
      dispense     <= 1'b0;
      dispense_amt <= 4'd0;
      err          <= 1'b0;
    end else begin
      state        <= state_nxt;
      mux_sel      <= screen_of(state_nxt);
      card_lock    <= (state_nxt == ST_LOCKED);
      card_q       <= card_in;
      tries        <= tries_nxt;
      balance      <= bal_nxt;
      dispense     <= disp_nxt;
      dispense_amt <= disp_amt_nxt;
      err          <= err_nxt;
    end
  end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed bench for atm_session_ctrl with default parameters.
module tb_atm_session_ctrl;
  import atm_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       card_in;
  logic       pin_valid;
  logic [3:0] pin;
  logic       op_valid;
  logic [1:0] op;
  logic [3:0] amt;
  logic [1:0] mux_sel;
  logic       dispense;
  logic [3:0] dispense_amt;
  logic [7:0] balance;
  logic       err;
  logic       card_lock;

  int n_checks;
  int n_fail;
  int exp_bal;

  atm_session_ctrl dut (
    .clk(clk), .rst_n(rst_n), .card_in(card_in),
    .pin_valid(pin_valid), .pin(pin),
    .op_valid(op_valid), .op(op), .amt(amt),
    .mux_sel(mux_sel), .dispense(dispense), .dispense_amt(dispense_amt),
    .balance(balance), .err(err), .card_lock(card_lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send_pin(input logic [3:0] p);
    pin = p; pin_valid = 1'b1;
    @(negedge clk);
    pin_valid = 1'b0;
  endtask

  task automatic send_op(input logic [1:0] o, input logic [3:0] a);
    op = o; amt = a; op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; card_in = 1'b0; pin_valid = 1'b0; pin = 4'd0;
    op_valid = 1'b0; op = 2'd0; amt = 4'd0;
    repeat (2) @(negedge clk);
    n_checks++; if (mux_sel !== SCR_IDLE) begin n_fail++; $display("FAIL rst_mux: got %0d want %0d", mux_sel, SCR_IDLE); end
    n_checks++; if (balance !== 8'd100) begin n_fail++; $display("FAIL rst_balance: got %0d want 100", balance); end
    n_checks++; if ({dispense, err, card_lock} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b want 000", {dispense, err, card_lock}); end
    n_checks++; if (dispense_amt !== 4'd0) begin n_fail++; $display("FAIL rst_damt: got %0d want 0", dispense_amt); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (mux_sel !== SCR_IDLE) begin n_fail++; $display("FAIL rst_idle_hold: got %0d want %0d", mux_sel, SCR_IDLE); end
  endtask

  task automatic test_withdraw;
    card_in = 1'b1;
    @(negedge clk);
    n_checks++; if (mux_sel !== SCR_PIN) begin n_fail++; $display("FAIL wd_pin_screen: got %0d want %0d", mux_sel, SCR_PIN); end
    send_pin(4'd7);
    n_checks++; if (mux_sel !== SCR_MENU) begin n_fail++; $display("FAIL wd_menu_screen: got %0d want %0d", mux_sel, SCR_MENU); end
    send_op(OP_WITHDRAW, 4'd10);
    n_checks++; if (dispense !== 1'b1 || dispense_amt !== 4'd10) begin n_fail++; $display("FAIL wd_dispense: got %b/%0d want 1/10", dispense, dispense_amt); end
    n_checks++; if (balance !== 8'd90) begin n_fail++; $display("FAIL wd_balance: got %0d want 90", balance); end
    n_checks++; if (mux_sel !== SCR_RESULT) begin n_fail++; $display("FAIL wd_result_screen: got %0d want %0d", mux_sel, SCR_RESULT); end
    // A strobe while in RESULT must be ignored.
    send_op(OP_WITHDRAW, 4'd5);
    n_checks++; if (dispense !== 1'b0 || balance !== 8'd90 || err !== 1'b0) begin n_fail++; $display("FAIL wd_result_ignore: got d=%b b=%0d e=%b want 0/90/0", dispense, balance, err); end
    for (int i = 3; i <= 8; i++) begin
      @(negedge clk);
      n_checks++; if (mux_sel !== SCR_RESULT) begin n_fail++; $display("FAIL wd_hold_c%0d: got %0d want %0d", i, mux_sel, SCR_RESULT); end
    end
    @(negedge clk);
    n_checks++; if (mux_sel !== SCR_MENU) begin n_fail++; $display("FAIL wd_back_menu: got %0d want %0d", mux_sel, SCR_MENU); end
    n_checks++; if (dispense_amt !== 4'd10) begin n_fail++; $display("FAIL wd_damt_hold: got %0d want 10", dispense_amt); end
  endtask

  task automatic test_balance_op;
    send_op(OP_BALANCE, 4'd9);
    n_checks++; if (mux_sel !== SCR_RESULT || balance !== 8'd90 || dispense !== 1'b0) begin n_fail++; $display("FAIL bal_query: got m=%0d b=%0d d=%b want 3/90/0", mux_sel, balance, dispense); end
    repeat (8) @(negedge clk);
    n_checks++; if (mux_sel !== SCR_MENU) begin n_fail++; $display("FAIL bal_back_menu: got %0d want %0d", mux_sel, SCR_MENU); end
  endtask

  task automatic test_card_drop;
    card_in = 1'b0;
    send_op(OP_WITHDRAW, 4'd4);
    n_checks++; if (mux_sel !== SCR_IDLE || dispense !== 1'b0) begin n_fail++; $display("FAIL drop_idle: got m=%0d d=%b want 0/0", mux_sel, dispense); end
    n_checks++; if (balance !== 8'd90) begin n_fail++; $display("FAIL drop_balance: got %0d want 90", balance); end
  endtask

  task automatic test_lock;
    card_in = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 3; i++) begin
      send_pin(4'd3);
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL lock_err%0d: got %b want 1", i, err); end
      n_checks++; if (mux_sel !== ((i == 3) ? SCR_LOCKED : SCR_PIN)) begin n_fail++; $display("FAIL lock_screen%0d: got %0d", i, mux_sel); end
    end
    n_checks++; if (card_lock !== 1'b1) begin n_fail++; $display("FAIL lock_flag: got %b want 1", card_lock); end
    send_pin(4'd7);
    n_checks++; if (card_lock !== 1'b1 || mux_sel !== SCR_LOCKED || err !== 1'b0) begin n_fail++; $display("FAIL lock_ignore: got l=%b m=%0d e=%b want 1/3/0", card_lock, mux_sel, err); end
    card_in = 1'b0;
    @(negedge clk);
    n_checks++; if (card_lock !== 1'b0 || mux_sel !== SCR_IDLE) begin n_fail++; $display("FAIL lock_release: got l=%b m=%0d want 0/0", card_lock, mux_sel); end
  endtask

  task automatic test_tries_clear;
    card_in = 1'b1; @(negedge clk);
    send_pin(4'd3); send_pin(4'd3);
    card_in = 1'b0; @(negedge clk);
    card_in = 1'b1; @(negedge clk);
    send_pin(4'd3);
    send_pin(4'd3);
    n_checks++; if (mux_sel !== SCR_PIN || card_lock !== 1'b0) begin n_fail++; $display("FAIL tries_cleared: got m=%0d l=%b want 1/0", mux_sel, card_lock); end
    send_pin(4'd7);
    n_checks++; if (mux_sel !== SCR_MENU) begin n_fail++; $display("FAIL tries_menu: got %0d want %0d", mux_sel, SCR_MENU); end
  endtask

  task automatic test_timeout;
    repeat (999) @(negedge clk);
    n_checks++; if (mux_sel !== SCR_MENU) begin n_fail++; $display("FAIL to_menu_999: got %0d want %0d", mux_sel, SCR_MENU); end
    @(negedge clk);
    n_checks++; if (mux_sel !== SCR_IDLE) begin n_fail++; $display("FAIL to_menu_1000: got %0d want %0d", mux_sel, SCR_IDLE); end
    card_in = 1'b0; @(negedge clk);
    card_in = 1'b1; @(negedge clk);
    repeat (998) @(negedge clk);
    send_pin(4'd3);
    n_checks++; if (err !== 1'b1 || mux_sel !== SCR_PIN) begin n_fail++; $display("FAIL to_restart_strobe: got e=%b m=%0d want 1/1", err, mux_sel); end
    repeat (999) @(negedge clk);
    n_checks++; if (mux_sel !== SCR_PIN) begin n_fail++; $display("FAIL to_restart_hold: got %0d want %0d", mux_sel, SCR_PIN); end
    @(negedge clk);
    n_checks++; if (mux_sel !== SCR_IDLE) begin n_fail++; $display("FAIL to_restart_expire: got %0d want %0d", mux_sel, SCR_IDLE); end
  endtask

  task automatic test_insufficient;
    card_in = 1'b0; @(negedge clk);
    card_in = 1'b1; @(negedge clk);
    send_pin(4'd7);
    exp_bal = 90;
    for (int i = 0; i < 6; i++) begin
      send_op(OP_WITHDRAW, (i < 5) ? 4'd15 : 4'd10);
      exp_bal = exp_bal - ((i < 5) ? 15 : 10);
      n_checks++; if (balance !== exp_bal[7:0]) begin n_fail++; $display("FAIL drain%0d: got %0d want %0d", i, balance, exp_bal); end
      repeat (8) @(negedge clk);
    end
    send_op(OP_WITHDRAW, 4'd6);
    n_checks++; if (err !== 1'b1 || dispense !== 1'b0 || balance !== 8'd5) begin n_fail++; $display("FAIL nsf_6: got e=%b d=%b b=%0d want 1/0/5", err, dispense, balance); end
    n_checks++; if (mux_sel !== SCR_RESULT || dispense_amt !== 4'd10) begin n_fail++; $display("FAIL nsf_6_screen: got m=%0d da=%0d want 3/10", mux_sel, dispense_amt); end
    repeat (8) @(negedge clk);
    send_op(OP_WITHDRAW, 4'd5);
    n_checks++; if (dispense !== 1'b1 || dispense_amt !== 4'd5 || balance !== 8'd0 || err !== 1'b0) begin n_fail++; $display("FAIL exact_5: got d=%b da=%0d b=%0d e=%b want 1/5/0/0", dispense, dispense_amt, balance, err); end
    repeat (8) @(negedge clk);
    send_op(OP_WITHDRAW, 4'd0);
    n_checks++; if (dispense !== 1'b1 || dispense_amt !== 4'd0 || balance !== 8'd0 || err !== 1'b0) begin n_fail++; $display("FAIL zero_amt: got d=%b da=%0d b=%0d e=%b want 1/0/0/0", dispense, dispense_amt, balance, err); end
    repeat (8) @(negedge clk);
    send_op(OP_WITHDRAW, 4'd1);
    n_checks++; if (err !== 1'b1 || balance !== 8'd0) begin n_fail++; $display("FAIL nsf_empty: got e=%b b=%0d want 1/0", err, balance); end
    repeat (8) @(negedge clk);
    send_op(2'd3, 4'd0);
    n_checks++; if (mux_sel !== SCR_IDLE) begin n_fail++; $display("FAIL exit_op3: got %0d want %0d", mux_sel, SCR_IDLE); end
    @(negedge clk);
    n_checks++; if (mux_sel !== SCR_IDLE) begin n_fail++; $display("FAIL exit_stay_idle: got %0d want %0d", mux_sel, SCR_IDLE); end
  endtask

  task automatic test_reset_in_result;
    card_in = 1'b0; @(negedge clk);
    card_in = 1'b1; @(negedge clk);
    send_pin(4'd7);
    op = OP_WITHDRAW; amt = 4'd0; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    n_checks++; if (dispense !== 1'b1 || mux_sel !== SCR_RESULT) begin n_fail++; $display("FAIL rr_pre: got d=%b m=%0d want 1/3", dispense, mux_sel); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (dispense !== 1'b0 || err !== 1'b0 || card_lock !== 1'b0 || mux_sel !== SCR_IDLE) begin n_fail++; $display("FAIL rr_async: got d=%b e=%b l=%b m=%0d want 0/0/0/0", dispense, err, card_lock, mux_sel); end
    n_checks++; if (balance !== 8'd100 || dispense_amt !== 4'd0) begin n_fail++; $display("FAIL rr_balance: got b=%0d da=%0d want 100/0", balance, dispense_amt); end
    card_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (mux_sel !== SCR_IDLE || balance !== 8'd100) begin n_fail++; $display("FAIL rr_after: got m=%0d b=%0d want 0/100", mux_sel, balance); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_withdraw();
    test_balance_op();
    test_card_drop();
    test_lock();
    test_tries_clear();
    test_timeout();
    test_insufficient();
    test_reset_in_result();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
